lv_bist_seq: RTL and testbench

- Power-up/on-demand self-test sequencer for the LV domain.
- Runs NUM_ITEM analog BIST items one at a time through a one-hot enable. Each item is an lv_abist-style checker: enable in, done/fail out.
- After the analog items it launches logic BIST, then reports a per-item fail vector and an overall pass/fail.
- Sits between the top-level mode controller and the individual analog checkers.

---
 rtl/lv_bist_pkg.sv | 7 +
 rtl/lv_bist_timer.sv | 18 +
 rtl/lv_bist_seq.sv | 124 ++++++++++++
 tb/tb_lv_bist_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lv_bist_pkg.sv
// lv_bist_pkg: shared FSM state type and time-window helper for the LV BIST blocks
package lv_bist_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, ITEM, ITEM_GAP, LBIST, DONE, ABORT} bist_seq_st_e;
  function automatic int unsigned us2cyc(input int unsigned us, input int unsigned clk_m);
    return us * clk_m;
  endfunction
endpackage

// File: rtl/lv_bist_timer.sv
// lv_bist_timer: saturating window counter with clear; o_exp flags the count has reached i_win
module lv_bist_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic [W-1:0] i_win,
  output logic         o_exp
);
  logic [W-1:0] cnt;
  // count up from zero after each clear and stick at all-ones
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt <= '0;
    else if (i_clr) cnt <= '0;
    else if (!(&cnt)) cnt <= cnt + 1'b1;
  assign o_exp = cnt >= i_win;
endmodule

// File: rtl/lv_bist_seq.sv
// lv_bist_seq: LV self-test sequencer (analog items then logic BIST); LV_BIST_SEQ_ABORT_ON_FAIL_EN skips the rest after the first item fail
module lv_bist_seq
  import lv_bist_pkg::*;
#(
  parameter int unsigned CLK_M        = 48,
  parameter int unsigned NUM_ITEM     = 4,
  parameter int unsigned ITEM_TMO_US  = 100,
  parameter int unsigned LBIST_TMO_US = 500,
  parameter int unsigned SETTLE_US    = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_bist_req,
  output logic [NUM_ITEM-1:0] o_item_en,
  input  logic [NUM_ITEM-1:0] i_item_done,
  input  logic [NUM_ITEM-1:0] i_item_fail,
  output logic                o_lbist_start,
  input  logic                i_lbist_done,
  input  logic                i_lbist_fail,
  output logic                o_busy,
  output logic                o_done,
  output logic [NUM_ITEM-1:0] o_fail_vec,
  output logic                o_lbist_fail,
  output logic                o_bist_pass
);
  localparam int unsigned SET_C = us2cyc(SETTLE_US, CLK_M);
  localparam int unsigned ITM_C = us2cyc(ITEM_TMO_US, CLK_M);
  localparam int unsigned LB_C  = us2cyc(LBIST_TMO_US, CLK_M);
  localparam int unsigned MX1   = LB_C > ITM_C ? LB_C : ITM_C;
  localparam int unsigned MAX_C = MX1 > SET_C ? MX1 : SET_C;
  localparam int TW = $clog2(MAX_C + 1);
  localparam int IW = NUM_ITEM > 1 ? $clog2(NUM_ITEM) : 1;
  bist_seq_st_e st, st_d;
  logic [IW-1:0] idx, idx_d;
  logic [NUM_ITEM-1:0] fail_vec_d, done_q, fail_q;
  logic lbist_fail_d, pass_d, req_q, lb_done_q, lb_fail_q, tmr_exp;
  logic [TW-1:0] win;
  assign win = st == SETTLE ? TW'(SET_C - 1) : st == LBIST ? TW'(LB_C - 1) : TW'(ITM_C - 1);
  lv_bist_timer #(.W(TW)) u_tmr (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(st_d != st),
    .i_win(win),
    .o_exp(tmr_exp)
  );
  // next state and result updates; a dropped request outside IDLE/DONE/ABORT aborts
  always_comb begin
    st_d = st;
    idx_d = idx;
    fail_vec_d = o_fail_vec;
    lbist_fail_d = o_lbist_fail;
    pass_d = o_bist_pass;
    if (st == IDLE) begin
      if (i_bist_req && !req_q) begin
        st_d = SETTLE;
        idx_d = '0;
        fail_vec_d = '0;
        lbist_fail_d = 1'b0;
        pass_d = 1'b0;
      end
    end else if (!i_bist_req && st != DONE && st != ABORT) begin
      st_d = ABORT;
      pass_d = 1'b0;
    end else begin
      case (st)
        SETTLE: if (tmr_exp) st_d = ITEM;
        ITEM: if (done_q[idx] || tmr_exp) begin
          st_d = ITEM_GAP;
          fail_vec_d[idx] = done_q[idx] ? fail_q[idx] : 1'b1;
        end
        ITEM_GAP: begin
`ifdef LV_BIST_SEQ_ABORT_ON_FAIL_EN
          if (o_fail_vec[idx]) st_d = DONE;
          else
`endif
          if (idx == IW'(NUM_ITEM - 1)) st_d = LBIST;
          else begin
            st_d = ITEM;
            idx_d = idx + 1'b1;
          end
        end
        LBIST: if (lb_done_q || tmr_exp) begin
          st_d = DONE;
          lbist_fail_d = lb_done_q ? lb_fail_q : 1'b1;
        end
        default: st_d = IDLE;
      endcase
      if (st_d == DONE) pass_d = ~(|fail_vec_d | lbist_fail_d);
    end
  end
  // state, input samples and registered outputs derived from the next state
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      st <= IDLE;
      idx <= '0;
      req_q <= 1'b0;
      done_q <= '0;
      fail_q <= '0;
      lb_done_q <= 1'b0;
      lb_fail_q <= 1'b0;
      o_item_en <= '0;
      o_lbist_start <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_fail_vec <= '0;
      o_lbist_fail <= 1'b0;
      o_bist_pass <= 1'b0;
    end else begin
      st <= st_d;
      idx <= idx_d;
      req_q <= i_bist_req;
      done_q <= i_item_done & o_item_en;
      fail_q <= i_item_fail;
      lb_done_q <= i_lbist_done & o_lbist_start;
      lb_fail_q <= i_lbist_fail;
      o_item_en <= st_d == ITEM ? NUM_ITEM'(1) << idx_d : '0;
      o_lbist_start <= st_d == LBIST;
      o_busy <= st_d inside {SETTLE, ITEM, ITEM_GAP, LBIST};
      o_done <= st_d == DONE;
      o_fail_vec <= fail_vec_d;
      o_lbist_fail <= lbist_fail_d;
      o_bist_pass <= pass_d;
    end
endmodule

// File: tb/tb_lv_bist_seq.sv
// tb_lv_bist_seq: randomized self-check of lv_bist_seq against a timeline model
module tb_lv_bist_seq;
  localparam int CLK_M = 48;
  localparam int N = 4;
  localparam int S = 10 * CLK_M;
  localparam int T = 100 * CLK_M;
  localparam int L = 500 * CLK_M;
  localparam int NEVER = 32'h3fff_ffff;
`ifdef LV_BIST_SEQ_ABORT_ON_FAIL_EN
  localparam bit AF = 1'b1;
`else
  localparam bit AF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, req, lbs, ld, lfi, busy, dn, lfo, pass;
  logic [3:0] en, done_i, fail_i, fv;
  lv_bist_seq dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_bist_req(req),
    .o_item_en(en),
    .i_item_done(done_i),
    .i_item_fail(fail_i),
    .o_lbist_start(lbs),
    .i_lbist_done(ld),
    .i_lbist_fail(lfi),
    .o_busy(busy),
    .o_done(dn),
    .o_fail_vec(fv),
    .o_lbist_fail(lfo),
    .o_bist_pass(pass)
  );
  always #5 clk = ~clk;
  int n_chk, n_fail, sc_r, lcnt;
  int sc_d[4];
  int ecnt[4];
  bit sc_f[4];
  bit sc_lf, exp_lf, exp_pass;
  logic [3:0] exp_fv;
  logic [3:0] exp_en[$];
  bit exp_lb[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (en[k]) begin
        done_i[k] = ecnt[k] >= sc_d[k];
        fail_i[k] = done_i[k] ? sc_f[k] : 1'($urandom);
        ecnt[k]++;
      end else begin
        ecnt[k] = 0;
        done_i[k] = 1'($urandom);
        fail_i[k] = 1'($urandom);
      end
    end
    if (lbs) begin
      ld = lcnt >= sc_r;
      lfi = ld ? sc_lf : 1'($urandom);
      lcnt++;
    end else begin
      lcnt = 0;
      ld = 1'($urandom);
      lfi = 1'($urandom);
    end
  endtask
  task automatic set_all(input int d, input bit f);
    for (int k = 0; k < N; k++) begin
      sc_d[k] = d;
      sc_f[k] = f;
    end
  endtask
  task automatic build_model();
    int h;
    bit fl, stop;
    exp_en.delete();
    exp_lb.delete();
    exp_fv = '0;
    exp_lf = 1'b0;
    stop = 1'b0;
    repeat (S) begin
      exp_en.push_back(4'b0);
      exp_lb.push_back(1'b0);
    end
    for (int k = 0; k < N && !stop; k++) begin
      fl = (sc_d[k] + 2 <= T) ? sc_f[k] : 1'b1;
      h = (sc_d[k] + 2 <= T) ? sc_d[k] + 2 : T;
      exp_fv[k] = fl;
      repeat (h) begin
        exp_en.push_back(4'(1 << k));
        exp_lb.push_back(1'b0);
      end
      exp_en.push_back(4'b0);
      exp_lb.push_back(1'b0);
      stop = AF && fl;
    end
    if (!stop) begin
      exp_lf = (sc_r + 2 <= L) ? sc_lf : 1'b1;
      h = (sc_r + 2 <= L) ? sc_r + 2 : L;
      repeat (h) begin
        exp_en.push_back(4'b0);
        exp_lb.push_back(1'b1);
      end
    end
    exp_pass = exp_fv == 4'b0 && !exp_lf;
  endtask
  task automatic run_seq(input string tag);
    int mism, lat, k;
    build_model();
    k = exp_en.size();
    mism = 0;
    lat = -1;
    req = 1'b1;
    for (int j = 0; j <= k; j++) begin
      step();
      if (dn && lat < 0) lat = j;
      if (j == 0 && (fv !== 4'b0 || lfo !== 1'b0 || pass !== 1'b0)) mism++;
      if (j < k) begin
        if ({en, lbs, busy, dn} !== {exp_en[j], exp_lb[j], 2'b10}) mism++;
      end else if ({en, lbs, busy, dn} !== 7'b0000001) mism++;
    end
    chk({tag, "_trace"}, mism, 0);
    chk({tag, "_lat"}, lat, k);
    chk({tag, "_fail_vec"}, fv, exp_fv);
    chk({tag, "_lbist_fail"}, lfo, exp_lf);
    chk({tag, "_pass"}, pass, exp_pass);
    req = 1'b0;
    step();
    step();
    chk({tag, "_hold"}, {pass, busy, dn}, {exp_pass, 2'b00});
  endtask
  initial begin
    int b, n;
    n_chk = 0;
    n_fail = 0;
    req = 1'b0;
    done_i = '0;
    fail_i = '0;
    ld = 1'b0;
    lfi = 1'b0;
    set_all(0, 0);
    sc_r = 0;
    sc_lf = 0;
    rst = 1'b1;
    step();
    step();
    chk("reset", {en, lbs, busy, dn, fv, lfo, pass}, 0);
    rst = 1'b0;
    step();
    set_all(0, 0);
    sc_r = 20;
    run_seq("nominal");
    for (int k = 0; k < N; k++) sc_d[k] = $urandom_range(0, 4);
    sc_f[2] = 1'b1;
    run_seq("item2_fail");
    set_all(1, 0);
    sc_d[1] = NEVER;
    sc_d[3] = T - 2;
    sc_r = 3;
    run_seq("item_tmo");
    set_all(0, 0);
    sc_r = NEVER;
    run_seq("lbist_tmo");
    sc_r = L - 2;
    sc_lf = 1'b0;
    run_seq("lbist_tie");
    set_all(0, 0);
    sc_f[0] = 1'b1;
    sc_r = 5;
    run_seq("item0_fail");
    set_all(1, 0);
    sc_f[0] = !AF;
    sc_r = 10;
    req = 1'b1;
    b = 0;
    while (en !== 4'b0100 && b < 2000) begin
      step();
      b++;
    end
    chk("abort_reach", en, 4'b0100);
    req = 1'b0;
    step();
    chk("abort_out", {en, lbs, busy, dn}, 0);
    chk("abort_res", {fv, lfo, pass}, {3'b000, !AF, 2'b00});
    n = 0;
    repeat (5) begin
      step();
      if (dn) n++;
    end
    chk("abort_nodone", n, 0);
    set_all(2, 0);
    sc_r = 10;
    run_seq("restart");
    repeat (6) begin
      for (int k = 0; k < N; k++) begin
        sc_d[k] = $urandom_range(0, 6);
        sc_f[k] = $urandom_range(0, 3) == 0;
      end
      sc_r = $urandom_range(0, 40);
      sc_lf = $urandom_range(0, 3) == 0;
      run_seq("rand");
    end
    set_all(0, 0);
    sc_r = 20;
    sc_lf = 1'b0;
    req = 1'b1;
    repeat (S + 4) step();
    #2 rst = 1'b1;
    #1 chk("rst_mid", {en, lbs, busy, dn, fv, lfo, pass}, 0);
    req = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("rst_idle", {en, lbs, busy, dn, fv, lfo, pass}, 0);
    run_seq("post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
